ser7_deser: RTL and testbench
=============================

Name: ser7_deser

Overview:
- Serial-to-parallel front end for the 7-bit ones-count/encoder stages (q5/q6 family).
- Collects a framed serial bit stream into one 7-bit word and presents it on a valid/ready output.
- Holds the word in a one-entry output buffer until the downstream stage accepts it.
- Flags overrun and frame-abort conditions, so the combinational stage downstream only ever sees complete, stable words.

Parameters:
- WIDTH, 7, bits per frame; output word width.
- CNT_W, 3, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is valid this cycle.
- sof  input  1  start of frame; qualified by sin_valid; marks the bit on sin as bit 0.
- out_ready  input  1  downstream accepts y this cycle.
- clr_ovr  input  1  clears the sticky overrun flag.
- y  output  [0:WIDTH-1]  assembled word; y[0] is the first serial bit received.
- out_valid  output  1  y holds an unaccepted complete word.
- busy  output  1  FSM is in SHIFT (a frame is partially received).
- overrun  output  1  sticky; a completed word was dropped because the buffer was full.
- frame_err  output  1  one-cycle pulse; a partial frame was aborted by a new sof.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, bit counter=0, shift register=0, y=0, out_valid=0, busy=0, overrun=0, frame_err=0.
- Reset applied mid-frame or while out_valid=1 discards all state immediately, without waiting for a clock edge.
- FSM states: IDLE, SHIFT.
- IDLE:
  - sin_valid&&sof captures sin into shift[0], counter=1, next state SHIFT.
  - sin_valid without sof: bit ignored.
- SHIFT:
  - sin_valid&&!sof: sin goes to shift[counter] and counter increments.
  - sin_valid=0: state and counter hold (gaps between bits are legal).
  - sin_valid&&sof: the partial frame is discarded, frame_err pulses next cycle, sin goes to shift[0], counter=1, state stays SHIFT.
- Completion: the bit captured at counter==WIDTH-1 completes the word.
  - Next state is IDLE and counter returns to 0.
  - If sof is also asserted on that bit, the sof is treated as restart (rule above), not as completion.
- Output buffer load, evaluated in the completion cycle:
  - Buffer is free if out_valid==0, or if out_valid&&out_ready in that same cycle.
  - If free: y takes the full word (shift contents plus the final bit) and out_valid=1 from the next cycle. Latency is 1 clock from the last bit's edge to out_valid.
  - If not free: the word is dropped, y is unchanged, and overrun=1 next cycle.
- Handshake:
  - y is stable while out_valid=1 and out_ready=0.
  - out_valid&&out_ready with no simultaneous load clears out_valid next cycle. y keeps its last value.
  - Accept and load in the same cycle: out_valid stays 1 and y takes the new word.
- overrun: sticky. clr_ovr=1 clears it next cycle; if a drop occurs in the same cycle as clr_ovr, set wins.
- busy=1 exactly when the state is SHIFT.
- Deserialisation continues while the buffer is full; only the final load is blocked.

Decomposition:
- Package ser7_pkg: state enum (IDLE, SHIFT), and constants WIDTH=7 and CNT_W=3, shared with the q5/q6 bench.
- One sub-module, ser7_outbuf: a one-entry valid/ready holding register with load/accept/drop logic and the overrun flag.
- The FSM, counter and shift register stay in the top module.

Test Plan:
- Frame 1,1,1,0,0,0,1 with sof on the first bit and out_ready=1 -> y=7'b1110001 and out_valid=1 for one cycle, 1 clock after the 7th bit; busy=1 for bits 2..7.
- Same frame with sin_valid low for 3 cycles between bits 3 and 4 -> identical y; counter holds during the gap; out_valid is 3 cycles later.
- out_ready=0; send frame 0000001, then frame 1110010 -> y stays 7'b0000001, overrun=1 after the 2nd frame; clr_ovr pulse -> overrun=0.
- sof arrives at bit 4 of a frame, followed by 7 bits 1110010 -> frame_err pulses once, then y=7'b1110010.
- out_valid=1 with out_ready=1 asserted exactly in the completion cycle of the next frame -> no overrun, out_valid stays 1, y updates to the new word.
- rst_n low for 1ns mid-frame, asynchronously between edges -> all outputs 0 immediately; next frame 0000001 is received correctly.

Source files
------------

// File: rtl/ser7_pkg.sv
// ser7_pkg: constants and types shared by the ser7 deserialiser and the
// downstream q5/q6 ones-count/encoder stages.
//   WIDTH   : bits per serial frame / parallel word width
//   CNT_W   : bit-counter width (2**CNT_W >= WIDTH)
//   state_t : deserialiser FSM states
package ser7_pkg;

  localparam int WIDTH = 7;
  localparam int CNT_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/ser7_outbuf.sv
// ser7_outbuf: one-entry valid/ready holding register for completed words.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : a complete word is offered this cycle
//   word       : the offered word (word[0] = first serial bit)
//   out_ready  : downstream accepts y this cycle
//   clr_ovr    : clears the sticky overrun flag
//   y          : held word, stable while out_valid && !out_ready
//   out_valid  : y holds an unaccepted word
//   overrun    : sticky, a word was dropped because the buffer was full
module ser7_outbuf #(
  parameter int WIDTH = ser7_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [0:WIDTH-1] word,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [0:WIDTH-1] y,
  output logic             out_valid,
  output logic             overrun
);
  import ser7_pkg::*;

  logic [0:WIDTH-1] y_r;
  logic             valid_r;
  logic             ovr_r;
  logic             free_s;
  logic             drop_s;
  logic             accept_s;

  // Buffer is free when empty or being drained in this very cycle.
  always_comb begin
    free_s   = !valid_r || out_ready;
    accept_s = valid_r && out_ready;
    drop_s   = load && !free_s;
  end

  // Load / accept / hold of the word register and its valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r     <= '0;
      valid_r <= 1'b0;
    end else if (load && free_s) begin
      y_r     <= word;
      valid_r <= 1'b1;
    end else if (accept_s) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Sticky overrun; a drop in the same cycle as clr_ovr keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_r <= 1'b0;
    end else if (drop_s) begin
      ovr_r <= 1'b1;
    end else if (clr_ovr) begin
      ovr_r <= 1'b0;
    end else begin
      ovr_r <= ovr_r;
    end
  end

  assign y         = y_r;
  assign out_valid = valid_r;
  assign overrun   = ovr_r;

endmodule

// File: rtl/ser7_deser.sv
// ser7_deser: framed serial-to-parallel front end for the 7-bit q5/q6 stages.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sin        : serial data bit, qualified by sin_valid
//   sin_valid  : sin is valid this cycle
//   sof        : start of frame (bit on sin is bit 0), qualified by sin_valid
//   out_ready  : downstream accepts y this cycle
//   clr_ovr    : clears the sticky overrun flag
//   y          : assembled word, y[0] = first serial bit
//   out_valid  : y holds an unaccepted complete word
//   busy       : a frame is partially received (FSM in SHIFT)
//   overrun    : sticky, a completed word was dropped (buffer full)
//   frame_err  : one-cycle pulse, partial frame aborted by a new sof
module ser7_deser #(
  parameter int WIDTH = ser7_pkg::WIDTH,
  parameter int CNT_W = ser7_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [0:WIDTH-1] y,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);
  import ser7_pkg::*;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [0:WIDTH-1] shift_r;
  logic             busy_r;
  logic             frame_err_r;

  logic             last_s;
  logic             complete_s;
  logic [0:WIDTH-1] word_s;

  // Completion: the final bit arrives without sof; the word handed to the
  // buffer includes that bit directly so out_valid follows one clock later.
  always_comb begin
    last_s     = (cnt_r == CNT_W'(WIDTH - 1));
    complete_s = (state_r == SHIFT) && sin_valid && !sof && last_s;
    word_s     = shift_r;
    word_s[WIDTH-1] = sin;
  end

  // Frame FSM with bit counter, shift register and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      shift_r     <= '0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (sin_valid && sof) begin
            shift_r <= {sin, {(WIDTH-1){1'b0}}};
            cnt_r   <= CNT_W'(1);
            state_r <= SHIFT;
            busy_r  <= 1'b1;
          end
        end
        SHIFT: begin
          if (sin_valid && sof) begin
            // Restart wins even on the would-be final bit.
            shift_r     <= {sin, {(WIDTH-1){1'b0}}};
            cnt_r       <= CNT_W'(1);
            frame_err_r <= 1'b1;
          end else if (sin_valid) begin
            shift_r[cnt_r] <= sin;
            if (last_s) begin
              cnt_r   <= '0;
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  ser7_outbuf #(.WIDTH(WIDTH)) u_outbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (complete_s),
    .word      (word_s),
    .out_ready (out_ready),
    .clr_ovr   (clr_ovr),
    .y         (y),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  assign busy      = busy_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ser7_deser.sv
// tb_ser7_deser: table-driven directed bench for ser7_deser.
// Each row: inputs {sin_valid, sof, sin, out_ready, clr_ovr} for one cycle,
// and the outputs expected just after that cycle's rising edge:
// y and flags {out_valid, busy, overrun, frame_err}.
module tb_ser7_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sof = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [0:6] y;
  logic       out_valid;
  logic       busy;
  logic       overrun;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] in;
    logic [0:6] y;
    logic [3:0] fl;
  } vec_t;

  vec_t vecs[$];

  ser7_deser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sof       (sof),
    .out_ready (out_ready),
    .clr_ovr   (clr_ovr),
    .y         (y),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [4:0] i, input logic [0:6] ey, input logic [3:0] f);
    vec_t r;
    r.in = i;
    r.y  = ey;
    r.fl = f;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic run(input vec_t r, input string tag);
    {sin_valid, sof, sin, out_ready, clr_ovr} = r.in;
    @(posedge clk);
    #1;
    chk({tag, " y"}, y, r.y);
    chk({tag, " out_valid"}, {6'd0, out_valid}, {6'd0, r.fl[3]});
    chk({tag, " busy"}, {6'd0, busy}, {6'd0, r.fl[2]});
    chk({tag, " overrun"}, {6'd0, overrun}, {6'd0, r.fl[1]});
    chk({tag, " frame_err"}, {6'd0, frame_err}, {6'd0, r.fl[0]});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " y"}, y, 7'b0000000);
    chk({tag, " out_valid"}, {6'd0, out_valid}, 7'd0);
    chk({tag, " busy"}, {6'd0, busy}, 7'd0);
    chk({tag, " overrun"}, {6'd0, overrun}, 7'd0);
    chk({tag, " frame_err"}, {6'd0, frame_err}, 7'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // A: frame 1110001, out_ready=1
    add(5'b11110, 7'b0000000, 4'b0100);
    add(5'b10110, 7'b0000000, 4'b0100);
    add(5'b10110, 7'b0000000, 4'b0100);
    add(5'b10010, 7'b0000000, 4'b0100);
    add(5'b10010, 7'b0000000, 4'b0100);
    add(5'b10010, 7'b0000000, 4'b0100);
    add(5'b10110, 7'b1110001, 4'b1000);
    add(5'b00010, 7'b1110001, 4'b0000);
    // C: out_ready=0, frame 0000001 then 1110010 dropped, clr_ovr, accept
    add(5'b11000, 7'b1110001, 4'b0100);
    for (int k = 0; k < 5; k++) add(5'b10000, 7'b1110001, 4'b0100);
    add(5'b10100, 7'b0000001, 4'b1000);
    add(5'b11100, 7'b0000001, 4'b1100);
    add(5'b10100, 7'b0000001, 4'b1100);
    add(5'b10100, 7'b0000001, 4'b1100);
    add(5'b10000, 7'b0000001, 4'b1100);
    add(5'b10000, 7'b0000001, 4'b1100);
    add(5'b10100, 7'b0000001, 4'b1100);
    add(5'b10000, 7'b0000001, 4'b1010);
    add(5'b00001, 7'b0000001, 4'b1000);
    add(5'b00010, 7'b0000001, 4'b0000);
    // B: frame 1110001 with a 3-cycle gap after bit 3
    add(5'b11100, 7'b0000001, 4'b0100);
    add(5'b10100, 7'b0000001, 4'b0100);
    add(5'b10100, 7'b0000001, 4'b0100);
    for (int k = 0; k < 3; k++) add(5'b00000, 7'b0000001, 4'b0100);
    add(5'b10000, 7'b0000001, 4'b0100);
    add(5'b10000, 7'b0000001, 4'b0100);
    add(5'b10000, 7'b0000001, 4'b0100);
    add(5'b10100, 7'b1110001, 4'b1000);
    add(5'b00010, 7'b1110001, 4'b0000);
    // D: partial 1,0,1 aborted by sof at bit 4, then frame 1110010
    add(5'b11100, 7'b1110001, 4'b0100);
    add(5'b10000, 7'b1110001, 4'b0100);
    add(5'b10100, 7'b1110001, 4'b0100);
    add(5'b11100, 7'b1110001, 4'b0101);
    add(5'b10100, 7'b1110001, 4'b0100);
    add(5'b10100, 7'b1110001, 4'b0100);
    add(5'b10000, 7'b1110001, 4'b0100);
    add(5'b10000, 7'b1110001, 4'b0100);
    add(5'b10100, 7'b1110001, 4'b0100);
    add(5'b10000, 7'b1110010, 4'b1000);
    // E: frame 0101011, accept coincides with completion
    add(5'b11000, 7'b1110010, 4'b1100);
    add(5'b10100, 7'b1110010, 4'b1100);
    add(5'b10000, 7'b1110010, 4'b1100);
    add(5'b10100, 7'b1110010, 4'b1100);
    add(5'b10000, 7'b1110010, 4'b1100);
    add(5'b10100, 7'b1110010, 4'b1100);
    add(5'b10110, 7'b0101011, 4'b1000);
    add(5'b00010, 7'b0101011, 4'b0000);
    // F: sof on the would-be 7th bit restarts; new frame 1011010
    add(5'b11110, 7'b0101011, 4'b0100);
    for (int k = 0; k < 5; k++) add(5'b10110, 7'b0101011, 4'b0100);
    add(5'b11110, 7'b0101011, 4'b0101);
    add(5'b10010, 7'b0101011, 4'b0100);
    add(5'b10110, 7'b0101011, 4'b0100);
    add(5'b10110, 7'b0101011, 4'b0100);
    add(5'b10010, 7'b0101011, 4'b0100);
    add(5'b10110, 7'b0101011, 4'b0100);
    add(5'b10010, 7'b1011010, 4'b1000);
    add(5'b00010, 7'b1011010, 4'b0000);
    // G: frame 1111111 held (out_ready=0), then 3 bits of another frame
    add(5'b11100, 7'b1011010, 4'b0100);
    for (int k = 0; k < 5; k++) add(5'b10100, 7'b1011010, 4'b0100);
    add(5'b10100, 7'b1111111, 4'b1000);
    add(5'b11000, 7'b1111111, 4'b1100);
    add(5'b10100, 7'b1111111, 4'b1100);
    add(5'b10000, 7'b1111111, 4'b1100);

    // Reset state
    #2 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    #8 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run(vecs[i], $sformatf("v%0d", i));
    end

    // Asynchronous reset mid-frame with out_valid=1, between clock edges
    #2 rst_n = 1'b0;
    #0.5 chk_all_zero("async_rst");
    #0.5 rst_n = 1'b1;

    // H: frame 0000001 after the async reset
    begin
      vec_t r;
      r.in = 5'b11000; r.y = 7'b0000000; r.fl = 4'b0100; run(r, "h0");
      for (int k = 1; k < 6; k++) begin
        r.in = 5'b10000; r.y = 7'b0000000; r.fl = 4'b0100;
        run(r, $sformatf("h%0d", k));
      end
      r.in = 5'b10100; r.y = 7'b0000001; r.fl = 4'b1000; run(r, "h6");
      r.in = 5'b00010; r.y = 7'b0000001; r.fl = 4'b0000; run(r, "h7");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
